// File: rtl/ms_timer_bank.sv
// Bank of independent millisecond wait timers. Each channel has its own
// prescaler, target, one-shot/periodic mode, sticky done and overrun flags.

module ms_timer_chan #(
   parameter int COUNT_W  = 12,
   parameter int PRESCALE = 33334,
   parameter int PRE_W    = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic               i_periodic,
   input  logic [COUNT_W-1:0] i_target,
   input  logic               i_ack,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_overrun,
   output logic [COUNT_W-1:0] o_count
);
   logic [PRE_W-1:0]   r_pre;
   logic [COUNT_W-1:0] r_cnt;
   logic [COUNT_W-1:0] r_tgt;
   logic               r_mode;
   logic               r_busy;
   logic               r_done;
   logic               r_ovr;

   logic w_restart;
   logic w_roll;
   logic w_hit;
   logic w_expire;

   assign w_restart = i_start & ~i_stop;
   assign w_roll    = r_busy & (r_pre == PRE_W'(PRESCALE - 1));
   // cnt always stays below tgt while running, so one wider compare is enough
   assign w_hit     = (({1'b0, r_cnt} + (COUNT_W+1)'(1)) == {1'b0, r_tgt});
   assign w_expire  = w_roll & w_hit & ~i_stop & ~i_start;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pre  <= '0;
         r_cnt  <= '0;
         r_tgt  <= '0;
         r_mode <= 1'b0;
         r_busy <= 1'b0;
      end else if (i_stop) begin
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_tgt  <= i_target;
         r_mode <= i_periodic;
         r_pre  <= '0;
         r_cnt  <= '0;
         r_busy <= (i_target != '0);
      end else if (r_busy) begin
         if (w_roll) begin
            r_pre <= '0;
            if (w_hit) begin
               r_cnt  <= r_mode ? '0 : r_tgt;
               r_busy <= r_mode;
            end else begin
               r_cnt <= r_cnt + COUNT_W'(1);
            end
         end else begin
            r_pre <= r_pre + PRE_W'(1);
         end
      end
   end

   // Expiry beats a simultaneous ack; a start clears the flags regardless
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_done <= 1'b0;
         r_ovr  <= 1'b0;
      end else if (w_restart) begin
         r_done <= (i_target == '0);
         r_ovr  <= 1'b0;
      end else if (w_expire) begin
         r_done <= 1'b1;
         r_ovr  <= i_ack ? 1'b0 : (r_ovr | r_done);
      end else if (i_ack) begin
         r_done <= 1'b0;
         r_ovr  <= 1'b0;
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_overrun = r_ovr;
   assign o_count   = r_cnt;
endmodule

module ms_timer_bank #(
   parameter int CHANNELS = 4,
   parameter int COUNT_W  = 12,
   parameter int PRESCALE = 33334,
   parameter int PRE_W    = 16
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic [CHANNELS-1:0]         i_start,
   input  logic [CHANNELS-1:0]         i_stop,
   input  logic [CHANNELS-1:0]         i_periodic,
   input  logic [CHANNELS*COUNT_W-1:0] i_target,
   input  logic [CHANNELS-1:0]         i_ack,
   input  logic [CHANNELS-1:0]         i_irq_en,
   output logic [CHANNELS-1:0]         o_busy,
   output logic [CHANNELS-1:0]         o_done,
   output logic [CHANNELS-1:0]         o_overrun,
   output logic [CHANNELS*COUNT_W-1:0] o_count,
   output logic                        o_irq
);
   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      ms_timer_chan #(
         .COUNT_W (COUNT_W),
         .PRESCALE(PRESCALE),
         .PRE_W   (PRE_W)
      ) u_chan (
         .i_clk     (i_clk),
         .i_reset   (i_reset),
         .i_start   (i_start[i]),
         .i_stop    (i_stop[i]),
         .i_periodic(i_periodic[i]),
         .i_target  (i_target[i*COUNT_W +: COUNT_W]),
         .i_ack     (i_ack[i]),
         .o_busy    (o_busy[i]),
         .o_done    (o_done[i]),
         .o_overrun (o_overrun[i]),
         .o_count   (o_count[i*COUNT_W +: COUNT_W])
      );
   end

   assign o_irq = |(o_done & i_irq_en);
endmodule

// File: tb/tb_ms_timer_bank.sv
// Bench for ms_timer_bank with a short prescaler: table of vectors checked
// through a scoreboard queue, plus a hand-written async reset sequence.

module tb_ms_timer_bank;
   localparam int CH = 4;
   localparam int CW = 12;
   localparam int PS = 4;
   localparam int PW = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [CH-1:0]    start, stop, per, ack, en;
   logic [CH*CW-1:0] tgt;
   logic [CH-1:0]    busy, done, ovr;
   logic [CH*CW-1:0] cnt;
   logic             irq;

   ms_timer_bank #(.CHANNELS(CH), .COUNT_W(CW), .PRESCALE(PS), .PRE_W(PW)) dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_stop(stop),
      .i_periodic(per), .i_target(tgt), .i_ack(ack), .i_irq_en(en),
      .o_busy(busy), .o_done(done), .o_overrun(ovr), .o_count(cnt), .o_irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [3:0]   st, sp, pe, ak, en;
      logic [47:0]  tg;
      int           edges;
      logic [3:0]   e_busy, e_done, e_ovr;
      logic [47:0]  e_cnt;
      logic         e_irq;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [47:0] pk(input int c3, input int c2, input int c1, input int c0);
      return {12'(c3), 12'(c2), 12'(c1), 12'(c0)};
   endfunction

   function automatic vec_t mk(input string n, input logic [3:0] st, input logic [3:0] sp,
                               input logic [3:0] pe, input logic [3:0] ak, input logic [3:0] e,
                               input logic [47:0] tg, input int edges, input logic [3:0] eb,
                               input logic [3:0] ed, input logic [3:0] eo,
                               input logic [47:0] ec, input logic ei);
      vec_t v;
      v.name = n; v.st = st; v.sp = sp; v.pe = pe; v.ak = ak; v.en = e; v.tg = tg;
      v.edges = edges; v.e_busy = eb; v.e_done = ed; v.e_ovr = eo; v.e_cnt = ec; v.e_irq = ei;
      return v;
   endfunction

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   // Entered and left on a falling edge; strobes last exactly one rising edge
   task automatic run_vec(input vec_t v);
      vec_t e;
      start = v.st; stop = v.sp; per = v.pe; ack = v.ak; en = v.en; tgt = v.tg;
      sb.push_back(v);
      @(posedge clk);
      #1 start = '0; stop = '0; ack = '0;
      repeat (v.edges - 1) @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      chk({e.name, ".busy"},    64'(busy), 64'(e.e_busy));
      chk({e.name, ".done"},    64'(done), 64'(e.e_done));
      chk({e.name, ".overrun"}, 64'(ovr),  64'(e.e_ovr));
      chk({e.name, ".count"},   64'(cnt),  64'(e.e_cnt));
      chk({e.name, ".irq"},     64'(irq),  64'(e.e_irq));
   endtask

   initial begin
      rst = 1'b1; start = '0; stop = '0; per = '0; ack = '0; en = '1; tgt = '0;
      #12;
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.done", 64'(done), 64'd0);
      chk("rst.count", 64'(cnt), 64'd0);
      chk("rst.irq", 64'(irq), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      //            name   start  stop   per    ack    en     target         edges busy   done   ovr   count         irq
      tbl.push_back(mk("os0",  4'h1, 4'h0, 4'h0, 4'h0, 4'h1, pk(0,0,0,3), 1, 4'h1, 4'h0, 4'h0, pk(0,0,0,0), 1'b0));
      tbl.push_back(mk("os1",  4'h0, 4'h0, 4'h0, 4'h0, 4'h1, pk(0,0,0,3), 4, 4'h1, 4'h0, 4'h0, pk(0,0,0,1), 1'b0));
      tbl.push_back(mk("os2",  4'h0, 4'h0, 4'h0, 4'h0, 4'h1, pk(0,0,0,3), 4, 4'h1, 4'h0, 4'h0, pk(0,0,0,2), 1'b0));
      tbl.push_back(mk("os11", 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, pk(0,0,0,3), 3, 4'h1, 4'h0, 4'h0, pk(0,0,0,2), 1'b0));
      tbl.push_back(mk("os12", 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, pk(0,0,0,3), 1, 4'h0, 4'h1, 4'h0, pk(0,0,0,3), 1'b1));
      tbl.push_back(mk("osmsk",4'h0, 4'h0, 4'h0, 4'h0, 4'h0, pk(0,0,0,3), 1, 4'h0, 4'h1, 4'h0, pk(0,0,0,3), 1'b0));
      tbl.push_back(mk("osack",4'h0, 4'h0, 4'h0, 4'h1, 4'h1, pk(0,0,0,3), 1, 4'h0, 4'h0, 4'h0, pk(0,0,0,3), 1'b0));
      tbl.push_back(mk("pe0",  4'h2, 4'h0, 4'h2, 4'h0, 4'h0, pk(0,0,2,0), 1, 4'h2, 4'h0, 4'h0, pk(0,0,0,3), 1'b0));
      tbl.push_back(mk("pe7",  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, pk(0,0,2,0), 7, 4'h2, 4'h0, 4'h0, pk(0,0,1,3), 1'b0));
      tbl.push_back(mk("pe8",  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, pk(0,0,2,0), 1, 4'h2, 4'h2, 4'h0, pk(0,0,0,3), 1'b0));
      tbl.push_back(mk("pe16", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, pk(0,0,2,0), 8, 4'h2, 4'h2, 4'h2, pk(0,0,0,3), 1'b0));
      tbl.push_back(mk("peack",4'h0, 4'h0, 4'h0, 4'h2, 4'h0, pk(0,0,2,0), 1, 4'h2, 4'h0, 4'h0, pk(0,0,0,3), 1'b0));
      tbl.push_back(mk("pe24", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, pk(0,0,2,0), 7, 4'h2, 4'h2, 4'h0, pk(0,0,0,3), 1'b0));
      tbl.push_back(mk("pe31", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, pk(0,0,2,0), 7, 4'h2, 4'h2, 4'h0, pk(0,0,1,3), 1'b0));
      tbl.push_back(mk("ackexp",4'h0,4'h0, 4'h0, 4'h2, 4'h0, pk(0,0,2,0), 1, 4'h2, 4'h2, 4'h0, pk(0,0,0,3), 1'b0));
      tbl.push_back(mk("pe38", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, pk(0,0,2,0), 6, 4'h2, 4'h2, 4'h0, pk(0,0,1,3), 1'b0));
      tbl.push_back(mk("pe39", 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, pk(0,0,2,0), 1, 4'h2, 4'h0, 4'h0, pk(0,0,1,3), 1'b0));
      tbl.push_back(mk("stopx",4'h0, 4'h2, 4'h0, 4'h0, 4'h0, pk(0,0,2,0), 1, 4'h0, 4'h0, 4'h0, pk(0,0,1,3), 1'b0));
      tbl.push_back(mk("stopq",4'h0, 4'h0, 4'h0, 4'h0, 4'h0, pk(0,0,2,0), 8, 4'h0, 4'h0, 4'h0, pk(0,0,1,3), 1'b0));
      tbl.push_back(mk("rs0",  4'h4, 4'h0, 4'h0, 4'h0, 4'h0, pk(0,5,0,0),10, 4'h4, 4'h0, 4'h0, pk(0,2,1,3), 1'b0));
      tbl.push_back(mk("rs10", 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, pk(0,1,0,0), 1, 4'h4, 4'h0, 4'h0, pk(0,0,1,3), 1'b0));
      tbl.push_back(mk("rs13", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, pk(0,1,0,0), 3, 4'h4, 4'h0, 4'h0, pk(0,0,1,3), 1'b0));
      tbl.push_back(mk("rs14", 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, pk(0,1,0,0), 1, 4'h0, 4'h4, 4'h0, pk(0,1,1,3), 1'b1));
      tbl.push_back(mk("rs20", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, pk(0,1,0,0), 6, 4'h0, 4'h4, 4'h0, pk(0,1,1,3), 1'b0));
      tbl.push_back(mk("stst", 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, pk(7,0,0,0), 1, 4'h0, 4'h4, 4'h0, pk(0,1,1,3), 1'b0));
      tbl.push_back(mk("zero", 4'h3, 4'h0, 4'h2, 4'h0, 4'h3, pk(0,0,0,0), 1, 4'h0, 4'h7, 4'h0, pk(0,1,0,0), 1'b1));
      tbl.push_back(mk("zeroq",4'h0, 4'h0, 4'h0, 4'h0, 4'h0, pk(0,0,0,0),10, 4'h0, 4'h7, 4'h0, pk(0,1,0,0), 1'b0));
      tbl.push_back(mk("cc3",  4'hf, 4'h0, 4'h0, 4'h0, 4'h8, pk(4,3,2,1), 4, 4'hf, 4'h0, 4'h0, pk(0,0,0,0), 1'b0));
      tbl.push_back(mk("cc4",  4'h0, 4'h0, 4'h0, 4'h0, 4'h8, pk(4,3,2,1), 1, 4'he, 4'h1, 4'h0, pk(1,1,1,1), 1'b0));
      tbl.push_back(mk("cc8",  4'h0, 4'h0, 4'h0, 4'h0, 4'h8, pk(4,3,2,1), 4, 4'hc, 4'h3, 4'h0, pk(2,2,2,1), 1'b0));
      tbl.push_back(mk("cc12", 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, pk(4,3,2,1), 4, 4'h8, 4'h7, 4'h0, pk(3,3,2,1), 1'b0));
      tbl.push_back(mk("cc16", 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, pk(4,3,2,1), 4, 4'h0, 4'hf, 4'h0, pk(4,3,2,1), 1'b1));

      foreach (tbl[i]) run_vec(tbl[i]);

      // Async reset between edges while ch0 is mid-count
      start = 4'h1; per = '0; en = '1; tgt = pk(0,0,0,3);
      @(posedge clk);
      #1 start = '0;
      repeat (5) @(posedge clk);
      #2;
      chk("prerst.busy", 64'(busy), 64'h1);
      chk("prerst.irq", 64'(irq), 64'h1);
      #1 rst = 1'b1;
      #1;
      chk("arst.busy", 64'(busy), 64'd0);
      chk("arst.done", 64'(done), 64'd0);
      chk("arst.overrun", 64'(ovr), 64'd0);
      chk("arst.count", 64'(cnt), 64'd0);
      chk("arst.irq", 64'(irq), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("idle.busy", 64'(busy), 64'd0);
      chk("idle.done", 64'(done), 64'd0);
      chk("idle.count", 64'(cnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
